// File: rtl/countdown_arbiter_pkg.sv
// countdown_arb_pkg: FSM state encoding and round-robin pick helper for countdown_arbiter
package countdown_arb_pkg;
  localparam int MAX_REQ = 32;
  localparam int IDX_W = 5;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t DONE = 2'd2;
  typedef struct packed {
    logic valid;
    int   idx;
  } pick_t;
  // First set request searching ptr+1, ptr+2, ... modulo n; scanning offsets downward lets the nearest win.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    pick_t p;
    int k;
    p = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      k = (ptr + i) % n;
      if (i <= n && req[k[IDX_W-1:0]]) begin
        p.valid = 1'b1;
        p.idx = k;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/countdown_arbiter_if.sv
// countdown_arbiter_if: request/count/tick bus between clients and the shared countdown arbiter
interface countdown_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_WIDTH = 8
) ();
  logic [N_REQ-1:0]           i_req;
  logic [N_REQ*CNT_WIDTH-1:0] i_count;
  logic                       i_enable;
  logic [N_REQ-1:0]           o_grant;
  logic                       o_busy;
  logic [N_REQ-1:0]           o_done;
  logic [CNT_WIDTH-1:0]       o_remaining;
  modport master (output i_req, i_count, i_enable, input o_grant, o_busy, o_done, o_remaining);
  modport slave (input i_req, i_count, i_enable, output o_grant, o_busy, o_done, o_remaining);
endinterface

// File: rtl/countdown_arbiter_load.sv
// countdown_load: loadable down-counter that saturates at zero
module countdown_load #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);
  assign o_zero = ~|o_count;
  // Load has priority over the tick; the tick never takes the count below zero.
  always_ff @(posedge clock) begin
    if (i_reset) o_count <= '0;
    else if (i_load) o_count <= i_value;
    else if (i_enable && !o_zero) o_count <= o_count - 1'b1;
  end
endmodule

// File: rtl/countdown_arbiter.sv
// countdown_arbiter: round-robin sharing of one down-counter among N_REQ timeout clients
module countdown_arbiter
  import countdown_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic clock,
  input logic i_reset,
  countdown_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  state_t               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win;
  pick_t                pick;
  logic [CNT_WIDTH-1:0] sel;
  logic [CNT_WIDTH-1:0] count;
  logic [N_REQ-1:0]     onehot;
  logic                 zero;
  logic                 load;
  logic                 abort;
  // Pick the next owner and mux out its requested count.
  always_comb begin
    pick = rr_pick(MAX_REQ'(bus.i_req), N_REQ, int'(ptr));
    win = IW'(pick.idx);
    sel = '0;
    for (int k = 0; k < N_REQ; k++) sel = (win == IW'(k)) ? bus.i_count[k*CNT_WIDTH +: CNT_WIDTH] : sel;
  end
  assign load = state == IDLE && pick.valid;
  assign abort = state == RUN && !bus.i_req[owner];
  assign onehot = N_REQ'(1) << owner;
  countdown_load #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_load   (load || abort),
    .i_value  (abort ? '0 : sel),
    .i_enable (bus.i_enable && state == RUN),
    .o_count  (count),
    .o_zero   (zero)
  );
  // FSM, owner latch and RR pointer; abort beats expiry, DONE always returns to IDLE.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= IDLE;
      owner <= '0;
      ptr <= IW'(N_REQ - 1);
    end else begin
      state <= load ? RUN : (state == RUN && !abort) ? (zero ? DONE : RUN) : IDLE;
      owner <= load ? win : owner;
      ptr <= (abort || state == DONE) ? owner : ptr;
    end
  end
  assign bus.o_grant = state == RUN ? onehot : '0;
  assign bus.o_done = state == DONE ? onehot : '0;
  assign bus.o_busy = state != IDLE;
  assign bus.o_remaining = count;
endmodule
